// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the two-RAM pass sequencer.
package ram_ctrl_pkg;

    localparam int ADDR_W  = 9;
    localparam int LEN_W   = 10;
    localparam int MAX_LEN = 512;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    // Clamp a requested pass length to the size of the RAM.
    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    endfunction

endpackage

// File: rtl/addr_delay_line.sv
// Shift register of {valid, addr} that delays each read address until its
// write data is ready. 'pending' reports valid entries that have not yet
// reached the output stage, i.e. writes still to come after this cycle.
module addr_delay_line
    import ram_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic              pending
);

    logic [DEPTH-1:0]  valid_sr;
    logic [ADDR_W-1:0] addr_sr [DEPTH];

    // Advance the line by one stage per clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_sr <= '0;
            // NOTE: the address stages are reset too, not just the valid bits,
            // because the write address must read 0 straight out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                addr_sr[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let every stage sample its
            // neighbour's old value, so loop order does not matter.
            valid_sr[0] <= in_valid;
            addr_sr[0]  <= in_addr;
            for (int i = 1; i < DEPTH; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                addr_sr[i]  <= addr_sr[i-1];
            end
        end
    end

    // Any valid entry behind the output stage means the line is not drained.
    always_comb begin
        // NOTE: default first so the loop never leaves 'pending' unassigned
        // (which would infer a latch).
        pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            pending = pending | valid_sr[i];
        end
    end

    assign out_valid = valid_sr[DEPTH-1];
    assign out_addr  = addr_sr[DEPTH-1];

endmodule

// File: rtl/ram_pass_controller.sv
// Sequencer for the two-RAM read/modify/write datapath: streams an address
// window through the read ports and replays it, RD_LAT + PIPE_LAT cycles
// later, on the write ports. Supports abort, wrap-around and a done pulse.
module ram_pass_controller
    import ram_ctrl_pkg::*;
#(
    parameter int RD_LAT   = 1,
    parameter int PIPE_LAT = 1
) (
    input  logic       CLOCK_50_I,
    input  logic       RESET_I,
    input  logic       START_I,
    input  logic [8:0] START_ADDR_I,
    input  logic [9:0] LENGTH_I,
    input  logic [8:0] SPLIT_ADDR_I,
    input  logic       ABORT_I,
    output logic [8:0] RD_ADDR_O,
    output logic       RD_EN_O,
    output logic [8:0] WR_ADDR_O,
    output logic       WR_EN_O,
    output logic       WR_PHASE_O,
    output logic       BUSY_O,
    output logic       DONE_O,
    output logic       ABORTED_O
);

    // Read-to-write lag; must be at least 1 for the delay line to exist.
    localparam int LAG = RD_LAT + PIPE_LAT;

    state_t            state;
    state_t            next_state;
    logic [LEN_W-1:0]  start_len;
    logic [LEN_W-1:0]  remaining;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [ADDR_W-1:0] split_q;
    logic              aborted;
    logic              last_read;
    logic              line_pending;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;

    assign start_len = sat_len(LENGTH_I);

    // The read presented this cycle is the final one: count exhausted or abort.
    assign last_read = (state == S_READ) && (ABORT_I || (remaining == LEN_W'(1)));

    // State register.
    always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
        if (RESET_I) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: begin
                if (START_I) begin
                    next_state = (start_len == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (last_read) begin
                    next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!line_pending) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Read issue: capture the window at start, then step one address per cycle.
    always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
        if (RESET_I) begin
            rd_addr   <= '0;
            rd_en     <= 1'b0;
            remaining <= '0;
            split_q   <= '0;
            aborted   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START_I) begin
                        rd_addr   <= START_ADDR_I;
                        rd_en     <= (start_len != '0);
                        remaining <= start_len;
                        split_q   <= SPLIT_ADDR_I;
                        aborted   <= 1'b0;
                    end
                end
                S_READ: begin
                    if (last_read) begin
                        rd_en   <= 1'b0;
                        aborted <= ABORT_I;
                    end else begin
                        // 9-bit arithmetic wraps 511 back to 0.
                        rd_addr   <= rd_addr + ADDR_W'(1);
                        remaining <= remaining - LEN_W'(1);
                    end
                end
                default: begin
                    rd_en <= 1'b0;
                end
            endcase
        end
    end

    addr_delay_line #(
        .DEPTH (LAG)
    ) u_delay (
        .clk       (CLOCK_50_I),
        .rst       (RESET_I),
        .in_valid  (rd_en),
        .in_addr   (rd_addr),
        .out_valid (wr_valid),
        .out_addr  (wr_addr),
        .pending   (line_pending)
    );

    assign RD_ADDR_O  = rd_addr;
    assign RD_EN_O    = rd_en;
    assign WR_ADDR_O  = wr_addr;
    assign WR_EN_O    = wr_valid;
    assign WR_PHASE_O = wr_valid && (wr_addr >= split_q);
    assign BUSY_O     = (state != S_IDLE);
    assign DONE_O     = (state == S_DONE);
    assign ABORTED_O  = aborted;

endmodule

// File: doc/ram_pass_controller.md
# ram_pass_controller

Sequencer for the two-RAM read/modify/write datapath. On a start pulse it streams a configurable address window through the top (read) ports of both 512x8 dual-port RAMs. It drives the bottom (write) ports with the same address, delayed to match read latency plus datapath latency, and asserts write enable only when write data is valid. It replaces ad-hoc FSMs that are hard-wired to a full 0..511 sweep, and adds abort, wrap-around and a completion handshake.

## Interface
- RD_LAT, 1: RAM read latency in cycles (address to q).
- PIPE_LAT, 1: datapath latency in cycles (q to registered write data).
- Derived L = RD_LAT + PIPE_LAT: read-to-write address lag. L ≥ 1 is required.
- CLOCK_50_I  in  1  single clock; all logic on its rising edge.
- RESET_I  in  1  asynchronous, active-high reset.
- START_I  in  1  start request; sampled only in S_IDLE.
- START_ADDR_I  in  9  first address of the window.
- LENGTH_I  in  10  number of addresses; 0 means no-op; values >512 saturate to 512.
- SPLIT_ADDR_I  in  9  phase boundary for the datapath mode.
- ABORT_I  in  1  stops issuing reads; in-flight writes still complete.
- RD_ADDR_O  out  9  address to both RAM top ports.
- RD_EN_O  out  1  high when RD_ADDR_O carries a real read.
- WR_ADDR_O  out  9  address to both RAM bottom ports.
- WR_EN_O  out  1  write enable for both RAM bottom ports.
- WR_PHASE_O  out  1  1 when WR_ADDR_O ≥ SPLIT_ADDR_I; aligned with WR_EN_O.
- BUSY_O  out  1  high whenever the state is not S_IDLE.
- DONE_O  out  1  one-cycle completion pulse.
- ABORTED_O  out  1  valid with DONE_O; 1 if the pass was aborted.

## Operation
- States and transitions:
  - S_IDLE to S_READ on START_I when the saturated length is ≥1.
  - S_IDLE to S_DONE on START_I when LENGTH_I = 0.
  - S_READ to S_DRAIN after the last read issues, or on ABORT_I.
  - S_DRAIN to S_DONE once the delay line is empty.
  - S_DONE to S_IDLE unconditionally.
- START_ADDR_I, LENGTH_I and SPLIT_ADDR_I are captured at start. Later changes have no effect on the running pass.
- S_READ issues one read per cycle: RD_EN_O=1, RD_ADDR_O = start, start+1, … modulo 512 (511 wraps to 0). The remaining count decrements each cycle.
- Each issued {address, valid} enters an L-deep delay line. Its output drives WR_ADDR_O/WR_EN_O, so the write to address A occurs exactly L cycles after the read of A.
- ABORT_I sampled high in an S_READ cycle: the read presented in that cycle still completes and is written; no further reads. ABORT_I is ignored outside S_READ.
- START_I is ignored while BUSY_O=1.
- The datapath computes WR_PHASE_O from the delayed address. It is 0 whenever WR_EN_O=0.
- DONE_O=1 only in S_DONE. ABORTED_O holds its value until the next start.

## Timing
- Reset: the state goes to S_IDLE and every output is 0, immediately and asynchronously. The delay line is cleared, so no write is issued after reset, including mid-pass.
- START_I high at edge 0: S_READ from cycle 1, with the first RD_ADDR_O during cycle 1.
- For a length-N pass:
  - Reads occur in cycles 1..N.
  - Writes occur in cycles 1+L..N+L.
  - DONE_O is high in cycle N+L+1.
  - BUSY_O is high in cycles 1..N+L+1.
- LENGTH_I = 0: DONE_O is high in cycle 1, with no RD_EN_O and no WR_EN_O.
- A new START_I is accepted in the cycle after DONE_O (S_IDLE) at the earliest.
- Outputs are registered and have no combinational path from inputs.

## Structure
- Package ram_ctrl_pkg holds:
  - the state enum {S_IDLE, S_READ, S_DRAIN, S_DONE};
  - ADDR_W=9, LEN_W=10, MAX_LEN=512.
- Sub-module addr_delay_line: a parameterised-depth shift register of {valid, addr}, cleared by reset. The drain check is "no valid in the line".

## Test plan
- Full sweep (L=2): START_ADDR=0, LENGTH=512 → RD_ADDR 0..511 in cycles 1..512; WR_ADDR 0..511 with WR_EN in cycles 3..514; DONE_O in cycle 515, ABORTED_O=0.
- Wrap: START_ADDR=510, LENGTH=4 → reads and writes at 510, 511, 0, 1, each write lagging its read by 2; exactly 4 WR_EN cycles.
- Zero length: LENGTH=0 → DONE_O in cycle 1; RD_EN_O and WR_EN_O never asserted.
- Abort: START_ADDR=0, LENGTH=512, ABORT_I high in the cycle with RD_ADDR_O=9 → exactly 10 writes (0..9), then DONE_O with ABORTED_O=1.
- Phase plus ignored start: SPLIT=256, full sweep, START_I pulsed mid-pass → WR_PHASE_O=0 for writes 0..255 and 1 for 256..511; the pass is not restarted.
- Reset mid-pass: RESET_I high at read 100 → all outputs 0 in the same cycle; no WR_EN after reset is released until a new START_I.
